// File: rtl/serial_word_scanner_pkg.sv
// Shared encodings for the serial word scanner: sequencer states and the detector hit state.
package serial_word_scanner_pkg;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam logic [1:0] DET_HIT = 2'b11;
endpackage

// File: rtl/serial_word_scanner_detector.sv
// Two-bit T-flip-flop Moore ones-counter (mod 4); y is high in state {A,B} = 2'b11.
module t_ff (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic t,
   output logic q
);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      q <= 1'b0;
      else if (clr)  q <= 1'b0;
      else if (t)    q <= ~q;
   end
endmodule

module ones_mod4_detector
   import serial_word_scanner_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic x,
   output logic A,
   output logic B,
   output logic y
);
   // A toggles only when B is about to carry out: {A,B} counts ones mod 4
   t_ff u_ta (.clk(clk), .rst(rst), .clr(clr), .t(x & B), .q(A));
   t_ff u_tb (.clk(clk), .rst(rst), .clr(clr), .t(x),     .q(B));

   assign y = ({A, B} == DET_HIT);
endmodule

// File: rtl/serial_word_scanner.sv
// Sequencer that shifts a parallel word LSB-first into the mod-4 ones detector and counts hits.
// Optional SCAN_ABORT_EN adds an abort input that cancels a scan in progress without a done pulse.
module serial_word_scanner
   import serial_word_scanner_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
`ifdef SCAN_ABORT_EN
   input  logic             abort,
`endif
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] det_cnt,
   output logic             x_out,
   output logic             det_y,
   output logic [1:0]       det_state
);
   localparam int unsigned IDX_W = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] sreg;
   logic [IDX_W-1:0] idx;
   logic             accept;
   logic             abort_hit;
   logic             det_clr;
   logic             det_a;
   logic             det_b;

   assign busy   = (state == S_SHIFT) || (state == S_FLUSH);
   assign done   = (state == S_DONE);
   assign accept = (state == S_IDLE) && start;
`ifdef SCAN_ABORT_EN
   assign abort_hit = busy && abort;
`else
   assign abort_hit = 1'b0;
`endif
   assign det_clr   = accept || abort_hit;
   assign x_out     = (state == S_SHIFT) && sreg[0];
   assign det_state = {det_a, det_b};

   ones_mod4_detector u_det (
      .clk (clk),
      .rst (rst),
      .clr (det_clr),
      .x   (x_out),
      .A   (det_a),
      .B   (det_b),
      .y   (det_y)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         sreg    <= '0;
         idx     <= '0;
         det_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_SHIFT;
                  sreg    <= data_in;
                  idx     <= '0;
                  det_cnt <= '0;
               end
            end
            S_SHIFT: begin
               if (abort_hit) begin
                  state   <= S_IDLE;
                  det_cnt <= '0;
               end else begin
                  sreg    <= sreg >> 1;
                  idx     <= idx + 1'b1;
                  det_cnt <= det_cnt + CNT_W'(det_y);
                  if (idx == IDX_LAST) state <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               if (abort_hit) begin
                  state   <= S_IDLE;
                  det_cnt <= '0;
               end else begin
                  // Last bit's detector result only becomes visible here
                  det_cnt <= det_cnt + CNT_W'(det_y);
                  state   <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_word_scanner.sv
// Directed self-checking bench for serial_word_scanner (WIDTH=8, CNT_W=4).
module tb_serial_word_scanner;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] data_in = '0;
`ifdef SCAN_ABORT_EN
   logic       abort = 1'b0;
`endif
   logic       busy;
   logic       done;
   logic [3:0] det_cnt;
   logic       x_out;
   logic       det_y;
   logic [1:0] det_state;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   serial_word_scanner #(.WIDTH(8), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .data_in   (data_in),
`ifdef SCAN_ABORT_EN
      .abort     (abort),
`endif
      .busy      (busy),
      .done      (done),
      .det_cnt   (det_cnt),
      .x_out     (x_out),
      .det_y     (det_y),
      .det_state (det_state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full scan from IDLE; det_state/det_y/det_cnt tracked by a prefix-popcount model
   task automatic run_scan(input logic [7:0] d, input int unsigned exp_cnt);
      int unsigned pc;
      int unsigned acc;
      pc  = 0;
      acc = 0;
      start   = 1'b1;
      data_in = d;
      tick();
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check("shift_busy", busy, 1);
         check("shift_done", done, 0);
         check("x_out", x_out, d[k]);
         check("shift_state", det_state, pc);
         check("shift_y", det_y, (pc == 3) ? 1 : 0);
         check("shift_cnt", det_cnt, acc);
         if (pc == 3) acc++;
         pc = (pc + d[k]) % 4;
         tick();
      end
      check("flush_busy", busy, 1);
      check("flush_x", x_out, 0);
      check("flush_state", det_state, pc);
      if (pc == 3) acc++;
      tick();
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
      check("done_cnt", det_cnt, exp_cnt);
      check("model_cnt", acc, exp_cnt);
      tick();
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("idle_cnt", det_cnt, exp_cnt);
      check("idle_state_hold", det_state, pc);
   endtask

   initial begin
      int ndone;
      int d0;
      int d1;
      int d2;

      // Reset state
      @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cnt", det_cnt, 0);
      check("rst_x", x_out, 0);
      check("rst_y", det_y, 0);
      check("rst_state", det_state, 0);
      rst = 1'b1;
      tick();

      // Reset mid-scan of 8'hFF, then rerun
      start = 1'b1;
      data_in = 8'hFF;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      check("pre_rst_state", det_state, 3);
      rst = 1'b0;
      tick();
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_cnt", det_cnt, 0);
      check("midrst_state", det_state, 0);
      check("midrst_x", x_out, 0);
      rst = 1'b1;
      tick();
      check("after_rst_busy", busy, 0);
      run_scan(8'hFF, 2);

      run_scan(8'h07, 6);
      run_scan(8'h00, 0);
      run_scan(8'h0F, 1);
      run_scan(8'hA5, 2);

      // det_cnt stable in IDLE
      for (int i = 0; i < 5; i++) begin
         check("stable_cnt", det_cnt, 2);
         check("stable_done", done, 0);
         tick();
      end

      // start pulses during SHIFT (c3) and DONE (c10) must be ignored
      ndone = 0;
      d0 = -1;
      for (int c = 0; c < 25; c++) begin
         start   = (c == 0 || c == 3 || c == 10);
         data_in = (c == 0) ? 8'h07 : 8'hFF;
         if (done) begin
            ndone++;
            d0 = c;
         end
         tick();
      end
      start = 1'b0;
      check("ignore_ndone", ndone, 1);
      check("ignore_done_at", d0, 10);
      check("ignore_cnt", det_cnt, 6);
      check("ignore_busy", busy, 0);

      // start held high: back-to-back scans, done every 11 cycles
      ndone = 0;
      d0 = -1;
      d1 = -1;
      d2 = -1;
      for (int c = 0; c < 34; c++) begin
         start   = (c <= 22);
         data_in = 8'h0F;
         if (done) begin
            if (ndone == 0) d0 = c;
            else if (ndone == 1) d1 = c;
            else d2 = c;
            ndone++;
         end
         tick();
      end
      start = 1'b0;
      check("b2b_ndone", ndone, 3);
      check("b2b_first", d0, 10);
      check("b2b_second", d1, 21);
      check("b2b_third", d2, 32);
      check("b2b_cnt", det_cnt, 1);
      check("b2b_busy", busy, 0);

`ifdef SCAN_ABORT_EN
      // abort at SHIFT k=4 of 8'hFF
      start = 1'b1;
      data_in = 8'hFF;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      check("abort_pre_busy", busy, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_cnt", det_cnt, 0);
      check("abort_state", det_state, 0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) ndone++;
         tick();
      end
      check("abort_no_done", ndone, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_idle_ignored", busy, 0);
      run_scan(8'h07, 6);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
